rtc_read_sequencer: RTL and testbench
=====================================

Name: rtc_read_sequencer

Overview:
- Generates the RTC register read-address sequence for the read-side bus controller.
- Walks two contiguous register ranges: time block, then date block.
- Holds each address for a programmable number of clocks, or advances early on `next`.
- Parametrised successor to the fixed 11-address read walker: range bases and lengths, hold time and widths are parameters; adds single-pass mode, early advance, strobe/done handshake and a defined idle address.

Parameters:
- ADDR_W, 8, address width.
- HOLD_W, 12, hold counter width.
- HOLD_CYCLES, 256, clocks each address is held; range 1..2^HOLD_W.
- BASE_A, 8'h21, first address of range A.
- COUNT_A, 8, entries in range A; may be 0.
- BASE_B, 8'h41, first address of range B.
- COUNT_B, 3, entries in range B; may be 0. COUNT_A+COUNT_B must be at least 1.
- IDLE_ADDR, 8'hFF, value driven on `address` when not sequencing.
- IDX_W, 5, index width; must satisfy 2^IDX_W >= COUNT_A+COUNT_B.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- enable  in  1  read-walk enable (RW); low forces IDLE.
- mode_single  in  1  1 = one pass per `start`; 0 = continuous wrap.
- start  in  1  one-cycle pulse; launches a pass in single mode.
- next  in  1  advance to the next address now (bus controller finished early).
- address  out  ADDR_W  current register address.
- addr_valid  out  1  high while `address` carries a sequence entry.
- addr_strobe  out  1  one-cycle pulse in the first cycle of each new address.
- index  out  IDX_W  position in the sequence, 0..N-1 (N = COUNT_A+COUNT_B).
- pass_done  out  1  one-cycle pulse when entry N-1 completes.
- busy  out  1  high in HOLD.

Behaviour:
- All outputs are registered.
- Reset values: address=IDLE_ADDR, addr_valid=0, addr_strobe=0, index=0, pass_done=0, busy=0, state=IDLE, hold counter=0.
- Address map: index < COUNT_A gives BASE_A+index; otherwise BASE_B+(index-COUNT_A). Arithmetic is modulo 2^ADDR_W.
- State IDLE:
  - Outputs are at their reset values.
  - Go to HOLD when enable=1 and (mode_single=0 or start=1).
  - On entry: index=0, address=map(0), addr_valid=1, addr_strobe=1, busy=1, counter=0.
  - Latency: condition sampled at edge k; first address visible after edge k.
- State HOLD:
  - Counter increments each cycle.
  - Advance when counter==HOLD_CYCLES-1 or next=1. Both together give a single advance.
  - Without `next`, each address is present exactly HOLD_CYCLES cycles.
  - Advance from index < N-1: index+1, new address, addr_strobe=1, counter=0.
  - Advance from index N-1 with mode_single=0: wrap to index 0, addr_strobe=1, pass_done=1, stay in HOLD.
  - Advance from index N-1 with mode_single=1: pass_done=1, go to IDLE; address returns to IDLE_ADDR in the same cycle.
  - mode_single is sampled only at the N-1 advance; changing it mid-pass has no other effect.
  - start in HOLD is ignored.
- enable=0 in any state: IDLE on the next edge, with no pass_done and no strobe. Takes priority over next, start and terminal count.
- N=1: every advance is a last-entry advance. Continuous mode re-strobes the same address each HOLD_CYCLES.
- HOLD_CYCLES=1 with next=0: a new address every cycle; addr_strobe stays high continuously.
- Async reset asserted mid-pass: outputs go to reset values immediately. After release, IDLE waits for enable, plus start in single mode.

Test Plan:
- Defaults, mode_single=0, enable held 1 → addresses 21,22,…,28,41,42,43, each 256 cycles. pass_done pulses as 43→21 wraps. 11 strobes per pass.
- Single mode, start pulse → one pass of 11 addresses, pass_done once. Then address=FF, busy=0; a second start repeats the pass.
- Pulse next on cycle 10 of address 0x23 → 0x24 appears next cycle with strobe; its counter restarts, so 0x24 is held 256 cycles.
- Drop enable while holding 0x42 → next cycle address=FF, valid=0, no pass_done. Re-raise enable → sequence restarts at 0x21.
- Override COUNT_A=0, COUNT_B=2, HOLD_CYCLES=1 → addresses 41,42,41,42… every cycle, pass_done every 2nd cycle.
- Assert reset mid-hold and release → outputs at reset values immediately. Restart begins at index 0 on the first qualifying edge.

Source files
------------

// File: rtl/rtc_read_sequencer_if.sv
// Bus between the RTC read-address sequencer and the read-side bus controller.
// The controller supplies the walk controls. The sequencer returns the
// current register address and the handshake pulses.
interface rtc_read_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int IDX_W  = 5
);
    logic              enable;
    logic              mode_single;
    logic              start;
    logic              next;
    logic [ADDR_W-1:0] address;
    logic              addr_valid;
    logic              addr_strobe;
    logic [IDX_W-1:0]  index;
    logic              pass_done;
    logic              busy;

    // Sequencer side: drives the address and handshake outputs.
    modport master (
        input  enable, mode_single, start, next,
        output address, addr_valid, addr_strobe, index, pass_done, busy
    );

    // Bus-controller side: drives the walk controls.
    modport slave (
        output enable, mode_single, start, next,
        input  address, addr_valid, addr_strobe, index, pass_done, busy
    );
endinterface

// File: rtl/rtc_read_sequencer.sv
// RTC register read-address sequencer.
// The sequencer walks range A (time block) and then range B (date block).
// It holds each address for HOLD_CYCLES clocks, or advances early when the
// controller pulses next.
// It runs either continuously (wrapping) or one pass per start pulse.
// When not sequencing, it drives IDLE_ADDR.
module rtc_read_sequencer #(
    parameter int                ADDR_W      = 8,
    parameter int                HOLD_W      = 12,
    parameter int                HOLD_CYCLES = 256,
    parameter logic [ADDR_W-1:0] BASE_A      = 8'h21,
    parameter int                COUNT_A     = 8,
    parameter logic [ADDR_W-1:0] BASE_B      = 8'h41,
    parameter int                COUNT_B     = 3,
    parameter logic [ADDR_W-1:0] IDLE_ADDR   = 8'hFF,
    parameter int                IDX_W       = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    rtc_read_sequencer_if.master bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // HOLD_CYCLES may equal 2^HOLD_W. Its terminal value therefore still fits in HOLD_W bits.
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(COUNT_A + COUNT_B - 1);
    localparam logic [IDX_W:0]    CNT_A_EXT = (IDX_W + 1)'(COUNT_A);

    state_t            state_r,   state_s;
    logic [IDX_W-1:0]  index_r,   index_s;
    logic [HOLD_W-1:0] cnt_r,     cnt_s;
    logic [ADDR_W-1:0] address_r, address_s;
    logic              valid_r,   valid_s;
    logic              strobe_r,  strobe_s;
    logic              done_r,    done_s;
    logic              busy_r,    busy_s;

    logic              go_idle_s;
    logic              load_s;
    logic [IDX_W-1:0]  load_idx_s;
    logic              advance_s;

    // Map a sequence position to its register address.
    // The arithmetic wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] map_addr(input logic [IDX_W-1:0] idx);
        logic [ADDR_W-1:0] result;
        if ({1'b0, idx} < CNT_A_EXT) begin
            result = BASE_A + ADDR_W'(idx);
        end else begin
            result = BASE_B + ADDR_W'(idx) - ADDR_W'(COUNT_A);
        end
        return result;
    endfunction

    assign advance_s = (cnt_r == HOLD_LAST) || bus.next;

    // Next-state and next-output decision. Dropping enable overrides every other input.
    always_comb begin
        state_s    = state_r;
        index_s    = index_r;
        cnt_s      = cnt_r;
        address_s  = address_r;
        valid_s    = valid_r;
        strobe_s   = 1'b0;
        done_s     = 1'b0;
        busy_s     = busy_r;
        go_idle_s  = 1'b0;
        load_s     = 1'b0;
        load_idx_s = {IDX_W{1'b0}};

        if (!bus.enable) begin
            go_idle_s = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!bus.mode_single || bus.start) begin
                        load_s     = 1'b1;
                        load_idx_s = {IDX_W{1'b0}};
                    end else begin
                        go_idle_s = 1'b1;
                    end
                end
                ST_HOLD: begin
                    // A terminal count and next in the same cycle produce a single advance.
                    if (advance_s) begin
                        if (index_r == LAST_IDX) begin
                            done_s = 1'b1;
                            // mode_single matters only here, at the end of a pass.
                            if (bus.mode_single) begin
                                go_idle_s = 1'b1;
                            end else begin
                                load_s     = 1'b1;
                                load_idx_s = {IDX_W{1'b0}};
                            end
                        end else begin
                            load_s     = 1'b1;
                            load_idx_s = index_r + IDX_W'(1);
                        end
                    end else begin
                        load_s = 1'b0;
                    end
                end
                default: begin
                    go_idle_s = 1'b1;
                end
            endcase
        end

        if (go_idle_s) begin
            state_s   = ST_IDLE;
            index_s   = {IDX_W{1'b0}};
            cnt_s     = {HOLD_W{1'b0}};
            address_s = IDLE_ADDR;
            valid_s   = 1'b0;
            busy_s    = 1'b0;
        end else if (load_s) begin
            state_s   = ST_HOLD;
            index_s   = load_idx_s;
            cnt_s     = {HOLD_W{1'b0}};
            address_s = map_addr(load_idx_s);
            valid_s   = 1'b1;
            strobe_s  = 1'b1;
            busy_s    = 1'b1;
        end else begin
            cnt_s = cnt_r + HOLD_W'(1);
        end
    end

    // State and registered-output update with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            index_r   <= {IDX_W{1'b0}};
            cnt_r     <= {HOLD_W{1'b0}};
            address_r <= IDLE_ADDR;
            valid_r   <= 1'b0;
            strobe_r  <= 1'b0;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            index_r   <= index_s;
            cnt_r     <= cnt_s;
            address_r <= address_s;
            valid_r   <= valid_s;
            strobe_r  <= strobe_s;
            done_r    <= done_s;
            busy_r    <= busy_s;
        end
    end

    assign bus.address     = address_r;
    assign bus.addr_valid  = valid_r;
    assign bus.addr_strobe = strobe_r;
    assign bus.index       = index_r;
    assign bus.pass_done   = done_r;
    assign bus.busy        = busy_r;

endmodule

// File: tb/tb_rtc_read_sequencer.sv
// Directed, scoreboarded bench for rtc_read_sequencer.
// Expected strobed addresses are queued when stimulus is applied and popped on each strobe.
module tb_rtc_read_sequencer;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    rtc_read_sequencer_if #(.ADDR_W(8), .IDX_W(5)) a ();
    rtc_read_sequencer_if #(.ADDR_W(8), .IDX_W(5)) b ();

    rtc_read_sequencer u0 (
        .clk   (clk),
        .reset (reset),
        .bus   (a)
    );

    rtc_read_sequencer #(
        .COUNT_A     (0),
        .COUNT_B     (2),
        .HOLD_CYCLES (1)
    ) u1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b)
    );

    typedef struct {
        logic [7:0] addr;
        logic [4:0] idx;
    } exp_t;

    typedef struct {
        logic [7:0] addr;
        logic       done;
    } exp1_t;

    exp_t  q[$];
    exp1_t q1[$];

    logic [7:0] seq_tbl [11] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
                                 8'h27, 8'h28, 8'h41, 8'h42, 8'h43};

    int errors      = 0;
    int checks      = 0;
    int cyc         = 0;
    int last_strobe = 0;
    int last_gap    = 0;
    int done_cnt    = 0;
    int strobe_cnt  = 0;
    int d0          = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_range(input int from, input int to);
        for (int i = from; i <= to; i++) begin
            q.push_back('{seq_tbl[i], 5'(i)});
        end
    endtask

    // Advance one clock, sample u0 1 ns after the edge and score any strobe.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (a.pass_done === 1'b1) done_cnt++;
        if (a.addr_strobe === 1'b1) begin
            last_gap    = cyc - last_strobe;
            last_strobe = cyc;
            strobe_cnt++;
            if (q.size() == 0) begin
                chk("spurious_strobe", 32'(a.addr_strobe), 32'd0);
            end else begin
                e = q.pop_front();
                chk("strobe_addr",  32'(a.address),    32'(e.addr));
                chk("strobe_index", 32'(a.index),      32'(e.idx));
                chk("strobe_valid", 32'(a.addr_valid), 32'd1);
            end
        end
    endtask

    task automatic run_until_empty(input bit gap_chk, input int hold, input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            step();
            n++;
            if (gap_chk && a.addr_strobe === 1'b1) chk("hold_len", 32'(last_gap), 32'(hold));
        end
        chk("queue_drained", 32'(q.size()), 32'd0);
    endtask

    initial begin
        exp1_t e1;
        a.enable = 1'b0; a.mode_single = 1'b0; a.start = 1'b0; a.next = 1'b0;
        b.enable = 1'b0; b.mode_single = 1'b0; b.start = 1'b0; b.next = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_address", 32'(a.address),     32'h0000_00FF);
        chk("rst_valid",   32'(a.addr_valid),  32'd0);
        chk("rst_strobe",  32'(a.addr_strobe), 32'd0);
        chk("rst_index",   32'(a.index),       32'd0);
        chk("rst_done",    32'(a.pass_done),   32'd0);
        chk("rst_busy",    32'(a.busy),        32'd0);
        reset = 1'b1;
        step();

        // Continuous walk: launch latency, then a full pass with 256-cycle holds and a wrap.
        a.enable = 1'b1;
        push_range(0, 0);
        step();
        chk("launch_latency", 32'(q.size()), 32'd0);
        chk("launch_busy",    32'(a.busy),   32'd1);
        push_range(1, 10);
        push_range(0, 0);
        run_until_empty(1'b1, 256, 3000);
        chk("wrap_done_pulse",  32'(a.pass_done), 32'd1);
        chk("wrap_index",       32'(a.index),     32'd0);
        chk("wrap_done_count",  32'(done_cnt),    32'd1);
        chk("strobes_per_pass", 32'(strobe_cnt),  32'd12);

        // Drop enable while 0x42 is held.
        push_range(1, 9);
        run_until_empty(1'b1, 256, 2600);
        repeat (5) step();
        a.enable = 1'b0;
        step();
        chk("drop_address", 32'(a.address),     32'h0000_00FF);
        chk("drop_valid",   32'(a.addr_valid),  32'd0);
        chk("drop_strobe",  32'(a.addr_strobe), 32'd0);
        chk("drop_busy",    32'(a.busy),        32'd0);
        chk("drop_no_done", 32'(done_cnt),      32'd1);
        a.enable = 1'b1;
        push_range(0, 0);
        step();
        chk("restart_at_21", 32'(q.size()), 32'd0);

        // Early advance: next on cycle 10 of 0x23, then 0x24 held a full 256 cycles.
        push_range(1, 2);
        run_until_empty(1'b1, 256, 600);
        repeat (9) step();
        chk("pre_next_addr", 32'(a.address), 32'h0000_0023);
        a.next = 1'b1;
        push_range(3, 3);
        step();
        a.next = 1'b0;
        chk("next_advance", 32'(q.size()), 32'd0);
        chk("next_gap",     32'(last_gap), 32'd10);
        push_range(4, 4);
        run_until_empty(1'b1, 256, 300);

        // Single mode: wait for start; one pass; start mid-pass ignored; FF after the last entry.
        a.enable = 1'b0;
        step();
        a.mode_single = 1'b1;
        a.enable = 1'b1;
        repeat (4) step();
        chk("single_wait_addr", 32'(a.address), 32'h0000_00FF);
        chk("single_wait_busy", 32'(a.busy),    32'd0);
        a.start = 1'b1;
        push_range(0, 0);
        step();
        a.start = 1'b0;
        chk("single_launch", 32'(q.size()), 32'd0);
        d0 = done_cnt;
        push_range(1, 10);
        repeat (50) step();
        a.start = 1'b1;
        step();
        a.start = 1'b0;
        run_until_empty(1'b1, 256, 2600);
        repeat (255) step();
        chk("last_entry_hold", 32'(a.address),   32'h0000_0043);
        chk("last_entry_done", 32'(a.pass_done), 32'd0);
        step();
        chk("single_done",       32'(a.pass_done),    32'd1);
        chk("single_end_addr",   32'(a.address),      32'h0000_00FF);
        chk("single_end_valid",  32'(a.addr_valid),   32'd0);
        chk("single_end_busy",   32'(a.busy),         32'd0);
        chk("single_done_count", 32'(done_cnt - d0),  32'd1);
        repeat (5) step();
        chk("single_stays_idle", 32'(a.address), 32'h0000_00FF);
        a.start = 1'b1;
        push_range(0, 0);
        step();
        a.start = 1'b0;
        chk("second_start", 32'(q.size()), 32'd0);

        // Asynchronous reset mid-hold, then restart from index 0.
        repeat (20) step();
        reset = 1'b0;
        #1;
        chk("async_rst_address", 32'(a.address),    32'h0000_00FF);
        chk("async_rst_valid",   32'(a.addr_valid), 32'd0);
        chk("async_rst_busy",    32'(a.busy),       32'd0);
        chk("async_rst_index",   32'(a.index),      32'd0);
        step();
        reset = 1'b1;
        repeat (3) step();
        chk("post_rst_idle", 32'(a.address), 32'h0000_00FF);
        a.start = 1'b1;
        push_range(0, 0);
        step();
        a.start = 1'b0;
        chk("post_rst_launch", 32'(q.size()), 32'd0);
        chk("post_rst_index",  32'(a.index),  32'd0);
        a.enable = 1'b0;
        step();

        // COUNT_A=0, COUNT_B=2, HOLD_CYCLES=1: 41/42 every cycle, pass_done on each wrap.
        b.enable = 1'b1;
        q1.push_back('{8'h41, 1'b0});
        q1.push_back('{8'h42, 1'b0});
        q1.push_back('{8'h41, 1'b1});
        q1.push_back('{8'h42, 1'b0});
        q1.push_back('{8'h41, 1'b1});
        q1.push_back('{8'h42, 1'b0});
        while (q1.size() != 0) begin
            step();
            e1 = q1.pop_front();
            chk("short_addr",   32'(b.address),     32'(e1.addr));
            chk("short_strobe", 32'(b.addr_strobe), 32'd1);
            chk("short_done",   32'(b.pass_done),   32'(e1.done));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
